modarith_pipe: RTL
==================

Name: modarith_pipe

Overview:
- Parametrised, pipelined modular add/subtract unit: z = (x ± y) mod M, for operands already reduced below M.
- Generalises the fixed 256-bit mod-n adder:
  - configurable width and modulus;
  - runtime add/sub select;
  - valid/ready handshake with full backpressure;
  - pass-through tag;
  - out-of-range operand flag.
- Sits between the scalar/field datapath sequencer and the ECC point/scalar arithmetic stages (secp256k1 n or p).

Parameters:
- WIDTH, 256, operand/result width in bits.
- MODULUS, 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141, modulus M (WIDTH bits). Requires 1 < M < 2^WIDTH.
- TAG_W, 4, width of the transaction tag carried alongside the data.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_op  input  1  operation select: 0 = add, 1 = subtract (x − y).
- in_x  input  WIDTH  operand x.
- in_y  input  WIDTH  operand y.
- in_tag  input  TAG_W  opaque tag, returned with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_z  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.
- out_oor  output  1  x ≥ M or y ≥ M for this beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, out_z = 0, out_tag = 0, out_oor = 0.
  - Both stage valid bits = 0.
  - in_ready = 1 the first cycle after release.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Upstream must hold in_* stable while in_valid && !in_ready.
- Pipeline: two register stages, stall-all.
  - Global advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_ready and out_valid only; no path from in_valid).
- Stage 1 (captured on input transfer):
  - raw = {0,x} + {0,y} for add, {0,x} − {0,y} for sub, WIDTH+1 bits.
  - Also registers op, tag, and oor = (x ≥ M) | (y ≥ M).
  - On advance without input transfer, the stage 1 valid bit clears.
- Stage 2 (on advance, when stage 1 is valid):
  - add: t = raw − M (WIDTH+2 bits); z = t negative ? raw[WIDTH−1:0] : t[WIDTH−1:0].
  - sub: z = raw[WIDTH] (borrow) ? (raw + M)[WIDTH−1:0] : raw[WIDTH−1:0].
  - out_z, out_tag, out_oor and out_valid are registered outputs.
- Latency: result appears exactly 2 cycles after the input transfer when out_ready stays high.
- Throughput: one beat per cycle.
- Stall:
  - While out_valid && !out_ready, all stages and outputs hold.
  - No beat is lost or duplicated.
  - Order is preserved.
- Simultaneous in/out transfer in the same cycle is allowed at full rate.
- Operand range:
  - For x, y < M, out_z is the exact residue in [0, M).
  - For out-of-range inputs, out_oor = 1 and out_z is the single-correction value above (not fully reduced); no other side effect.
- Reset mid-operation: in-flight beats are discarded; nothing is emitted after release until new input.
- No X may propagate to out_z while out_valid = 0; data registers are reset to 0.

Decomposition:
- Shared package ecc_arith_pkg:
  - SECP256K1_N and SECP256K1_P constants;
  - op encoding constants OP_ADD = 0, OP_SUB = 1.
- One natural sub-module: modarith_correct, the combinational stage 2 correction (raw, op → z), reusable by the future mod-mul reduction stage.

Test Plan:
- WIDTH=8, M=251, add 250+250 → out_z=249 after 2 cycles; 250+1 → 0; 0+0 → 0; all out_oor=0.
- WIDTH=8, M=251, sub 3−5 → 249; 5−3 → 2; 7−7 → 0; tags 1, 2, 3 returned in order.
- Default params, add (n−1)+(n−1) → n−2; sub 0−1 → n−1; add 2^255 + 0 with 2^255 < n → 2^255 unchanged.
- Backpressure: back-to-back stream of 8 beats, out_ready toggled 1-0-0-1 pattern. Required:
  - in_ready low exactly when out_valid && !out_ready;
  - all 8 results correct, in order, no duplicates;
  - full-rate run gives 1 beat/cycle.
- Out-of-range: WIDTH=8, M=251, add x=255, y=0 → out_oor=1, out_z=4.
- Reset: assert rst with 2 beats in flight → out_valid drops asynchronously; after release no result until a new input, whose result arrives 2 cycles after it is accepted.

Source files
------------

// File: rtl/ecc_arith_pkg.sv
// Shared constants for the ECC scalar/field arithmetic datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ecc_arith_pkg;

  // secp256k1 group order n and field prime p
  localparam logic [255:0] SECP256K1_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // operation select encoding carried on in_op
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/modarith_correct.sv
// Single-step modular correction of a raw add/sub result: z = raw mod M (one fold).
// Latency: combinational. Backpressure: none (pure function of raw, op).
// Ports: raw (WIDTH+1 bits, x+y or x-y with borrow in MSB), op (add/sub), z (WIDTH bits).
module modarith_correct
  import ecc_arith_pkg::*;
#(
  parameter int                 WIDTH   = 256,
  parameter logic [WIDTH-1:0]   MODULUS = WIDTH'(SECP256K1_N)
) (
  input  logic [WIDTH:0]   raw,
  input  logic             op,
  output logic [WIDTH-1:0] z
);

  // raw >= M is the same test as "raw - M is non-negative"; the low WIDTH
  // bits of raw - M and raw + M do not depend on the carry-out, so plain
  // WIDTH-bit arithmetic gives the folded value.
  logic             raw_ge_m;
  logic [WIDTH-1:0] raw_sub_m;
  logic [WIDTH-1:0] raw_add_m;

  assign raw_ge_m  = (raw >= {1'b0, MODULUS});
  assign raw_sub_m = raw[WIDTH-1:0] - MODULUS;
  assign raw_add_m = raw[WIDTH-1:0] + MODULUS;

  always_comb begin
    z = raw[WIDTH-1:0];
    if (op == OP_ADD) begin
      if (raw_ge_m) z = raw_sub_m;
    end else begin
      // MSB of a WIDTH+1 bit difference of zero-extended operands is the borrow
      if (raw[WIDTH]) z = raw_add_m;
    end
  end

endmodule

// File: rtl/modarith_pipe.sv
// Pipelined modular add/sub z = (x +/- y) mod M with tag pass-through and out-of-range flag.
// Latency: 2 cycles input transfer to out_valid; one beat per cycle sustained.
// Backpressure: stall-all; in_ready = !out_valid || out_ready, no path from in_valid.
// Ports: clk/rst (async active-high), in_valid/in_ready/in_op/in_x/in_y/in_tag upstream,
//        out_valid/out_ready/out_z/out_tag/out_oor downstream (all outputs registered).
module modarith_pipe
  import ecc_arith_pkg::*;
#(
  parameter int                 WIDTH   = 256,
  parameter logic [WIDTH-1:0]   MODULUS = WIDTH'(SECP256K1_N),
  parameter int                 TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_oor
);

  typedef struct packed {
    logic [WIDTH:0]   raw;
    logic             op;
    logic [TAG_W-1:0] tag;
    logic             oor;
  } s1_t;

  logic             advance;
  logic             in_fire;
  s1_t              s1_nxt;
  s1_t              s1_dat;
  logic             s1_vld;
  logic [WIDTH-1:0] corr_z;

  // The whole pipe moves together: only a held output blocks progress.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign in_fire  = in_valid && advance;

  always_comb begin
    s1_nxt.raw = (in_op == OP_SUB) ? ({1'b0, in_x} - {1'b0, in_y})
                                   : ({1'b0, in_x} + {1'b0, in_y});
    s1_nxt.op  = in_op;
    s1_nxt.tag = in_tag;
    s1_nxt.oor = (in_x >= MODULUS) || (in_y >= MODULUS);
  end

  modarith_correct #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_correct (
    .raw (s1_dat.raw),
    .op  (s1_dat.op),
    .z   (corr_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_dat    <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
      out_oor   <= 1'b0;
    end else if (advance) begin
      s1_vld    <= in_valid;
      out_valid <= s1_vld;
      if (in_fire) s1_dat <= s1_nxt;
      if (s1_vld) begin
        out_z   <= corr_z;
        out_tag <= s1_dat.tag;
        out_oor <= s1_dat.oor;
      end
    end
  end

endmodule
